// File: rtl/phase_gen.sv
// phase_gen: N-phase non-overlapping clock-enable generator with run/step control, frame counter and sync.
// Latency 1 cycle from RUN/STEP sample to PH[0]; no backpressure. Optional macro PHASE_GEN_RTCFG_EN adds PW_CFG/GW_CFG.
module phase_gen #(
  parameter int PHASES  = 2,
  parameter int PHASE_W = 1,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic              STEP,
`ifdef PHASE_GEN_RTCFG_EN
  input  logic [7:0]        PW_CFG,
  input  logic [7:0]        GW_CFG,
`endif
  output logic [PHASES-1:0] PH,
  output logic              O_S,
  output logic              SYNC,
  output logic              BUSY,
  output logic [CNT_W-1:0]  MCYC
);

  localparam int KW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [KW-1:0]     K_LAST = KW'(PHASES - 1);
  localparam logic [PHASES-1:0] PH_ONE = PHASES'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  state_t            r_state;
  logic [KW-1:0]     r_k;
  logic [7:0]        r_cnt;
  logic [PHASES-1:0] r_ph;
  logic              r_os;
  logic              r_sync;
  logic              r_busy;
  logic [CNT_W-1:0]  r_mcyc;

  logic [7:0] w_pw;
  logic [7:0] w_gw;

`ifdef PHASE_GEN_RTCFG_EN
  // Per-frame widths, captured whenever a frame starts.
  logic [7:0] r_pw;
  logic [7:0] r_gw;
  assign w_pw = r_pw;
  assign w_gw = r_gw;
`else
  assign w_pw = 8'(PHASE_W);
  assign w_gw = 8'(GAP_W);
`endif

  logic w_act_done;
  logic w_gap_done;
  logic w_last;
  logic w_frame_end;
  logic w_start;
  logic w_next_ph;

  assign w_act_done  = (r_state == S_ACTIVE) && (r_cnt == w_pw - 8'd1);
  assign w_gap_done  = (r_state == S_GAP) && (r_cnt == w_gw - 8'd1);
  assign w_last      = (r_k == K_LAST);
  assign w_frame_end = w_last && ((w_act_done && (w_gw == 8'd0)) || w_gap_done);
  assign w_start     = ((r_state == S_IDLE) && (RUN || STEP)) || (w_frame_end && RUN);
  assign w_next_ph   = !w_last && ((w_act_done && (w_gw == 8'd0)) || w_gap_done);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cnt   <= 8'd0;
      r_ph    <= '0;
      r_os    <= 1'b1;
      r_sync  <= 1'b0;
      r_busy  <= 1'b0;
      r_mcyc  <= '0;
`ifdef PHASE_GEN_RTCFG_EN
      r_pw    <= 8'(PHASE_W);
      r_gw    <= 8'(GAP_W);
`endif
    end else begin
      r_sync <= 1'b0;
      if (w_frame_end) begin
        r_os   <= ~r_os;
        r_mcyc <= r_mcyc + CNT_W'(1);
      end
      if (w_start) begin
        r_state <= S_ACTIVE;
        r_k     <= '0;
        r_cnt   <= 8'd0;
        r_ph    <= PH_ONE;
        r_sync  <= 1'b1;
        r_busy  <= 1'b1;
`ifdef PHASE_GEN_RTCFG_EN
        r_pw    <= (PW_CFG == 8'd0) ? 8'd1 : PW_CFG;
        r_gw    <= GW_CFG;
`endif
      end else if (w_frame_end) begin
        r_state <= S_IDLE;
        r_k     <= '0;
        r_cnt   <= 8'd0;
        r_ph    <= '0;
        r_busy  <= 1'b0;
      end else if (w_next_ph) begin
        r_state <= S_ACTIVE;
        r_k     <= r_k + 1'b1;
        r_cnt   <= 8'd0;
        r_ph    <= PH_ONE << (r_k + 1'b1);
      end else if (w_act_done) begin
        r_state <= S_GAP;
        r_cnt   <= 8'd0;
        r_ph    <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt   <= r_cnt + 8'd1;
      end
    end
  end

  assign PH   = r_ph;
  assign O_S  = r_os;
  assign SYNC = r_sync;
  assign BUSY = r_busy;
  assign MCYC = r_mcyc;

endmodule
